// File: rtl/sprite_sequencer.sv
// Sprite animation sequencer: raster-scans a window of frame ROM pixels to a
// VGA plotter, dwells between frames, and finishes with a full-screen end image.
// Optional macro SPRITE_SEQ_PINGPONG_EN selects ping-pong frame order instead
// of wrap-around order.
module sprite_sequencer #(
    parameter int unsigned NUM_FRAMES   = 4,
    parameter int unsigned X0           = 0,
    parameter int unsigned Y0           = 75,
    parameter int unsigned WIN_W        = 320,
    parameter int unsigned WIN_H        = 165,
    parameter int unsigned DWELL_CYCLES = 100000000,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              end_req,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [2:0]        frame_sel,
    output logic [8:0]        x,
    output logic [7:0]        y,
    output logic              plot,
    output logic              frame_done,
    output logic              end_active
);

    localparam int unsigned COL_W   = 9;
    localparam int unsigned ROW_W   = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES + 1);

    localparam logic [COL_W-1:0]   WIN_LAST_COL = COL_W'(WIN_W - 1);
    localparam logic [ROW_W-1:0]   WIN_LAST_ROW = ROW_W'(WIN_H - 1);
    localparam logic [COL_W-1:0]   END_LAST_COL = COL_W'(319);
    localparam logic [ROW_W-1:0]   END_LAST_ROW = ROW_W'(239);
    localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(NUM_FRAMES - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST   = DWELL_W'(DWELL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DRAW     = 3'd1,
        S_WAIT     = 3'd2,
        S_END_DRAW = 3'd3,
        S_END_HOLD = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [IDX_W-1:0]   frame_idx;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               end_pend;

    logic               win_last_c;
    logic               end_last_c;
    logic               row_end_c;
    logic               dwell_done_c;
    logic               issue_c;
    logic               enter_draw_c;
    logic               enter_end_c;
    logic               advance_c;
    logic [IDX_W-1:0]   idx_nxt_c;
    logic [IDX_W-1:0]   draw_idx_c;

    // Raster position decodes for the window and the full end screen
    assign win_last_c   = (col == WIN_LAST_COL) && (row == WIN_LAST_ROW);
    assign end_last_c   = (col == END_LAST_COL) && (row == END_LAST_ROW);
    assign row_end_c    = (state == S_DRAW) ? (col == WIN_LAST_COL) : (col == END_LAST_COL);
    assign dwell_done_c = (dwell_cnt == DWELL_LAST);

`ifdef SPRITE_SEQ_PINGPONG_EN
    logic dir_down;
    logic dir_down_nxt_c;

    // Ping-pong successor: bounce at both ends without repeating the end frame
    always_comb begin
        idx_nxt_c      = frame_idx;
        dir_down_nxt_c = dir_down;
        if (!dir_down) begin
            if (frame_idx == LAST_IDX) begin
                idx_nxt_c      = frame_idx - IDX_W'(1);
                dir_down_nxt_c = 1'b1;
            end else begin
                idx_nxt_c      = frame_idx + IDX_W'(1);
            end
        end else begin
            if (frame_idx == '0) begin
                idx_nxt_c      = IDX_W'(1);
                dir_down_nxt_c = 1'b0;
            end else begin
                idx_nxt_c      = frame_idx - IDX_W'(1);
            end
        end
    end

    // Direction bit updates only when a new frame is actually started from WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_down <= 1'b0;
        end else if ((state == S_WAIT) && (state_nxt == S_DRAW)) begin
            dir_down <= dir_down_nxt_c;
        end
    end
`else
    // Wrap-around successor
    assign idx_nxt_c = (frame_idx == LAST_IDX) ? '0 : frame_idx + IDX_W'(1);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a pending end request is honoured only from WAIT so the
    // last pixel of a frame always drains under its own frame_sel
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (end_req)    state_nxt = S_END_DRAW;
                else if (start) state_nxt = S_DRAW;
            end
            S_DRAW: begin
                if (win_last_c) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (end_req || end_pend) state_nxt = S_END_DRAW;
                else if (dwell_done_c)   state_nxt = S_DRAW;
            end
            S_END_DRAW: begin
                if (end_last_c) state_nxt = S_END_HOLD;
            end
            S_END_HOLD: state_nxt = S_END_HOLD;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Control strobes derived from current and next state
    always_comb begin
        issue_c      = 1'b0;
        enter_draw_c = 1'b0;
        enter_end_c  = 1'b0;
        advance_c    = 1'b0;
        draw_idx_c   = frame_idx;
        issue_c      = (state == S_DRAW) || (state == S_END_DRAW);
        enter_draw_c = (state_nxt == S_DRAW) && (state != S_DRAW);
        enter_end_c  = (state_nxt == S_END_DRAW) && (state != S_END_DRAW);
        advance_c    = issue_c && (state_nxt == state);
        if (state == S_WAIT) begin
            draw_idx_c = idx_nxt_c;
        end
    end

    // Pixel counters, address, frame bookkeeping and registered VGA outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            rom_addr   <= '0;
            frame_idx  <= '0;
            dwell_cnt  <= '0;
            end_pend   <= 1'b0;
            frame_sel  <= 3'd1;
            x          <= 9'(X0);
            y          <= 8'(Y0);
            plot       <= 1'b0;
            frame_done <= 1'b0;
            end_active <= 1'b0;
        end else begin
            plot       <= issue_c;
            frame_done <= (state == S_DRAW) && win_last_c;
            end_active <= (state_nxt == S_END_DRAW) || (state_nxt == S_END_HOLD);
            dwell_cnt  <= (state == S_WAIT) ? dwell_cnt + DWELL_W'(1) : '0;

            if (issue_c) begin
                x <= (state == S_DRAW) ? 9'(X0) + col : col;
                y <= (state == S_DRAW) ? 8'(Y0) + row : row;
            end

            if ((state == S_DRAW) && end_req) begin
                end_pend <= 1'b1;
            end

            if (enter_draw_c) begin
                col       <= '0;
                row       <= '0;
                rom_addr  <= '0;
                frame_idx <= draw_idx_c;
                frame_sel <= draw_idx_c + 3'd1;
            end else if (enter_end_c) begin
                col       <= '0;
                row       <= '0;
                rom_addr  <= '0;
                frame_sel <= 3'd0;
            end else if (advance_c) begin
                rom_addr <= rom_addr + ADDR_W'(1);
                if (row_end_c) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_sequencer.sv
// Scoreboard bench for sprite_sequencer: stimulus pushes expected plotted
// pixels, a negedge monitor pops and compares them as the DUT plots.
module tb_sprite_sequencer;

    localparam int unsigned NF   = 3;
    localparam int unsigned WW   = 4;
    localparam int unsigned WH   = 2;
    localparam int unsigned XO   = 10;
    localparam int unsigned YO   = 20;
    localparam int unsigned DW   = 3;
    localparam int unsigned AW   = 17;

    logic          clk;
    logic          reset;
    logic          start;
    logic          end_req;
    logic [AW-1:0] rom_addr;
    logic [2:0]    frame_sel;
    logic [8:0]    x;
    logic [7:0]    y;
    logic          plot;
    logic          frame_done;
    logic          end_active;

    sprite_sequencer #(
        .NUM_FRAMES  (NF),
        .X0          (XO),
        .Y0          (YO),
        .WIN_W       (WW),
        .WIN_H       (WH),
        .DWELL_CYCLES(DW),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .end_req   (end_req),
        .rom_addr  (rom_addr),
        .frame_sel (frame_sel),
        .x         (x),
        .y         (y),
        .plot      (plot),
        .frame_done(frame_done),
        .end_active(end_active)
    );

    typedef struct {
        int sel;
        int px;
        int py;
        int addr;
    } px_t;

    px_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int fd_cnt   = 0;
    bit strict   = 1'b1;
    bit chk_gap  = 1'b0;
    bit seen     = 1'b0;
    int low_run  = 0;
    int prev_addr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic push_frame(input int sel);
        px_t e;
        for (int r = 0; r < int'(WH); r++) begin
            for (int c = 0; c < int'(WW); c++) begin
                e.sel  = sel;
                e.px   = int'(XO) + c;
                e.py   = int'(YO) + r;
                e.addr = r * int'(WW) + c;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_end(input int n);
        px_t e;
        for (int i = 0; i < n; i++) begin
            e.sel  = 0;
            e.px   = i % 320;
            e.py   = i / 320;
            e.addr = i;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_q_empty(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout, %0d pixels still expected", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rom_addr"},   int'(rom_addr),   0);
        check({tag, "_frame_sel"},  int'(frame_sel),  1);
        check({tag, "_x"},          int'(x),          int'(XO));
        check({tag, "_y"},          int'(y),          int'(YO));
        check({tag, "_plot"},       int'(plot),       0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_end_active"}, int'(end_active), 0);
    endtask

    // Monitor: compare every plotted pixel against the head of the scoreboard
    always @(negedge clk) begin
        px_t e;
        if (!reset) begin
            if (frame_done) fd_cnt++;
            if (plot) begin
                if (chk_gap && low_run > 0) begin
                    if (seen) check("idle_gap", low_run, 3);
                    seen = 1'b1;
                end
                low_run = 0;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pix_sel",  int'(frame_sel), e.sel);
                    check("pix_x",    int'(x),         e.px);
                    check("pix_y",    int'(y),         e.py);
                    check("pix_addr", prev_addr,       e.addr);
                end else if (strict) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_plot: got x=%0d y=%0d sel=%0d expected no plot", x, y, frame_sel);
                end
            end else begin
                low_run++;
            end
        end
        prev_addr = int'(rom_addr);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seq[$];
        int n;

        reset   = 1'b1;
        start   = 1'b0;
        end_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("rst");
        @(posedge clk);
        #1 reset = 1'b0;

        // Free-running animation with the dwell gap checked between frames
`ifdef SPRITE_SEQ_PINGPONG_EN
        seq = '{1, 2, 3, 2, 1, 2};
`else
        seq = '{1, 2, 3, 1};
`endif
        fd_cnt  = 0;
        chk_gap = 1'b1;
        seen    = 1'b0;
        foreach (seq[i]) push_frame(seq[i]);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (fd_cnt < seq.size() && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("freerun_frame_done", fd_cnt, seq.size());
        check("freerun_drained", exp_q.size(), 0);
        exp_q.delete();
        chk_gap = 1'b0;

        // Now in the first WAIT cycle; reset lands on the second one
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values("wait_rst");
        repeat (3) @(negedge clk);
        check("idle_plot", int'(plot), 0);

        // Restart, then request the end screen partway through frame 2
        #1;
        fd_cnt = 0;
        push_frame(1);
        push_frame(2);
        push_end(76800);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!(frame_sel == 3'd2 && rom_addr == AW'(3)) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("end_req_point_sel", int'(frame_sel), 2);
        end_req = 1'b1;
        wait_q_empty("end_draw", 80000);
        check("end_active_draw", int'(end_active), 1);
        check("end_frame_done", fd_cnt, 2);
        check("end_frame_sel", int'(frame_sel), 0);
        repeat (10) @(negedge clk);
        check("hold_plot", int'(plot), 0);
        check("hold_x", int'(x), 319);
        check("hold_y", int'(y), 239);
        check("hold_addr", int'(rom_addr), 76799);
        check("hold_end_active", int'(end_active), 1);

        // start and end_req together from IDLE go straight to the end screen
        #1;
        end_req = 1'b0;
        reset   = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        fd_cnt = 0;
        strict = 1'b0;
        push_end(8);
        @(posedge clk);
        #1;
        start   = 1'b1;
        end_req = 1'b1;
        wait_q_empty("idle_end", 100);
        check("idle_end_active", int'(end_active), 1);
        check("idle_end_sel", int'(frame_sel), 0);
        check("idle_end_no_frame", fd_cnt, 0);
        start   = 1'b0;
        end_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
